// File: rtl/mealy_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mealy_seq_pkg
// Brief    : State encoding and default widths for the mealy_seq_tx serializer
// Revision : 1.0 - initial release
// ============================================================================
package mealy_seq_pkg;

    localparam int c_pat_w_dflt = 8;
    localparam int c_rep_w_dflt = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mealy_seq_tx.sv
`default_nettype none
// ============================================================================
// Module   : mealy_seq_tx
// Brief    : Repeating MSB-first pattern serializer with stall, gap and abort
// Revision : 1.0 - initial release
// ============================================================================
module mealy_seq_tx
    import mealy_seq_pkg::*;
#(
    parameter int PAT_W = c_pat_w_dflt,
    parameter int REP_W = c_rep_w_dflt,
    localparam int LEN_W = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [REP_W-1:0] r_reps;
    logic [LEN_W-1:0] w_idx_dec;

    assign w_idx_dec = r_idx - 1'b1;

    // r_idx always names the bit currently on bit_out (or the last one sent
    // while stalled), so each ena-qualified edge retires it and presents the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_reps      <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state     <= IDLE;
                bit_out     <= 1'b0;
                bit_valid   <= 1'b0;
                frame_start <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && ena && !abort) begin
                            r_pat       <= pattern;
                            r_len       <= len;
                            r_reps      <= reps;
                            r_idx       <= len;
                            bit_out     <= pattern[len];
                            bit_valid   <= 1'b1;
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                            r_state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        bit_out     <= 1'b0;
                        bit_valid   <= 1'b0;
                        frame_start <= 1'b0;
                        if (ena) begin
                            if (r_idx == '0) begin
                                if (r_reps != '0) begin
                                    r_reps  <= r_reps - 1'b1;
                                    r_state <= GAP;
                                end else begin
                                    done    <= 1'b1;
                                    r_state <= DONE;
                                end
                            end else begin
                                r_idx     <= w_idx_dec;
                                bit_out   <= r_pat[w_idx_dec];
                                bit_valid <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (ena) begin
                            r_idx       <= r_len;
                            bit_out     <= r_pat[r_len];
                            bit_valid   <= 1'b1;
                            frame_start <= 1'b1;
                            r_state     <= SHIFT;
                        end
                    end
                    DONE: begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_seq_tx
// Brief    : Self-checking bench for mealy_seq_tx (vector table + random model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] reps;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic b;
        logic v;
        logic fs;
        logic bz;
        logic dn;
    } outs_t;

    typedef struct {
        logic [7:0]  pat;
        logic [2:0]  len;
        logic [3:0]  reps;
        int          nbits;
        logic [63:0] stream;
        int          done_cyc;
        int          n_fs;
    } vec_t;

    outs_t       q_exp[$];
    outs_t       exp_o;
    bit          m_busy;
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs[7];
    logic [63:0] acc;
    int          nb;
    int          nfs;
    int          dcyc;
    int          cyc;

    always #5 clk = ~clk;

    mealy_seq_tx #(
        .PAT_W(8),
        .REP_W(4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done)
    );

    function automatic outs_t got_o();
        return outs_t'({bit_out, bit_valid, frame_start, busy, done});
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Whole transfer expressed as the list of cycles it should show once ena allows.
    function automatic void model_load(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
        q_exp.delete();
        for (int f = 0; f <= int'(r); f++) begin
            for (int i = int'(l); i >= 0; i--)
                q_exp.push_back(outs_t'({p[i], 1'b1, 1'(i == int'(l)), 1'b1, 1'b0}));
            if (f < int'(r))
                q_exp.push_back(outs_t'(5'b00010));
        end
        q_exp.push_back(outs_t'(5'b00011));
    endfunction

    function automatic void model_edge();
        if (!m_busy) begin
            if (start && ena && !abort) begin
                model_load(pattern, len, reps);
                exp_o  = q_exp.pop_front();
                m_busy = 1'b1;
            end else begin
                exp_o = '0;
            end
        end else if (abort || exp_o.dn) begin
            q_exp.delete();
            exp_o  = '0;
            m_busy = 1'b0;
        end else if (ena) begin
            exp_o = q_exp.pop_front();
        end else begin
            exp_o = outs_t'(5'b00010);
        end
    endfunction

    task automatic cycle(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check(name, {59'd0, got_o()}, {59'd0, exp_o});
    endtask

    task automatic observe();
        cyc++;
        if (bit_valid) begin
            acc = {acc[62:0], bit_out};
            nb++;
        end
        if (frame_start) nfs++;
        if (done && dcyc < 0) dcyc = cyc;
    endtask

    task automatic clear_obs();
        acc  = '0;
        nb   = 0;
        nfs  = 0;
        dcyc = -1;
        cyc  = 0;
    endtask

    task automatic begin_xfer(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r,
                              input string name);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        ena     = 1'b1;
        abort   = 1'b0;
        clear_obs();
        cycle(name);
        observe();
        start = 1'b0;
    endtask

    // Bounded: a transfer that never completes leaves dcyc at -1 and fails its check.
    task automatic drain(input string name, input bit hold_start);
        for (int c = 0; c < 80 && dcyc < 0; c++) begin
            if (hold_start) begin
                start   = 1'b1;
                pattern = 8'($urandom);
                len     = 3'($urandom);
                reps    = 4'($urandom);
            end
            cycle(name);
            observe();
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check({name, "_async"}, {59'd0, got_o()}, 64'd0);
        q_exp.delete();
        exp_o  = '0;
        m_busy = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check({name, "_held"}, {59'd0, got_o()}, 64'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; reps = '0;
        m_busy = 1'b0; exp_o = '0;
        clear_obs();

        vecs[0] = '{8'b1011_0000, 3'd3, 4'd0,  4,  64'h0,           5,  1};
        vecs[1] = '{8'b0000_1011, 3'd3, 4'd0,  4,  64'b1011,        5,  1};
        vecs[2] = '{8'h05,        3'd2, 4'd2,  9,  64'b101101101,   12, 3};
        vecs[3] = '{8'hA5,        3'd7, 4'd0,  8,  64'hA5,          9,  1};
        vecs[4] = '{8'h3C,        3'd7, 4'd1,  16, 64'h3C3C,        18, 2};
        vecs[5] = '{8'h01,        3'd0, 4'd15, 16, 64'hFFFF,        32, 16};
        vecs[6] = '{8'hFE,        3'd0, 4'd0,  1,  64'h0,           2,  1};

        #2;
        do_reset("reset");
        cycle("idle_after_reset");

        // Table: start held high with scrambled inputs during each transfer.
        for (int k = 0; k < 7; k++) begin
            begin_xfer(vecs[k].pat, vecs[k].len, vecs[k].reps, "vec_accept");
            drain("vec_cyc", 1'b1);
            start = 1'b0;
            check("vec_stream",   acc,          vecs[k].stream);
            check("vec_nbits",    64'(nb),      64'(vecs[k].nbits));
            check("vec_fs_count", 64'(nfs),     64'(vecs[k].n_fs));
            check("vec_done_cyc", 64'(dcyc),    64'(vecs[k].done_cyc));
            cycle("vec_idle");
        end

        // Stall for three cycles after the second bit.
        begin_xfer(8'hA5, 3'd7, 4'd0, "stall_accept");
        cycle("stall_bit2");
        observe();
        ena = 1'b0;
        repeat (3) begin
            cycle("stall_cyc");
            observe();
            check("stall_valid", 64'(bit_valid), 64'd0);
        end
        ena = 1'b1;
        drain("stall_drain", 1'b0);
        check("stall_stream",   acc,     64'hA5);
        check("stall_done_cyc", 64'(dcyc), 64'd12);
        cycle("stall_idle");

        // Abort while the third bit is on the line, then immediate restart.
        begin_xfer(8'h96, 3'd7, 4'd0, "abort_accept");
        cycle("abort_bit2");
        cycle("abort_bit3");
        abort = 1'b1;
        cycle("abort_edge");
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        abort = 1'b0;
        start = 1'b1; pattern = 8'h5A; len = 3'd7; reps = 4'd0;
        clear_obs();
        cycle("abort_restart");
        observe();
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_fs",   64'(frame_start), 64'd1);
        start = 1'b0;
        drain("restart_drain", 1'b0);
        check("restart_stream", acc, 64'h5A);

        // Back-to-back: start held across DONE is taken after one idle cycle.
        start = 1'b1; pattern = 8'h0C; len = 3'd3; reps = 4'd0;
        cycle("b2b_idle");
        check("b2b_idle_busy", 64'(busy), 64'd0);
        clear_obs();
        cycle("b2b_accept");
        observe();
        check("b2b_accept_busy", 64'(busy), 64'd1);
        start = 1'b0;
        drain("b2b_drain", 1'b0);
        check("b2b_stream", acc, 64'b1100);
        cycle("b2b_end");

        // Abort and start together in IDLE: rejected.
        abort = 1'b1; start = 1'b1;
        cycle("idle_abort_start");
        check("idle_abort_busy", 64'(busy), 64'd0);
        abort = 1'b0; start = 1'b0;

        // Reset while in the inter-frame gap, start held through reset.
        begin_xfer(8'h05, 3'd2, 4'd2, "gap_accept");
        cycle("gap_bit2");
        cycle("gap_bit3");
        cycle("gap_enter");
        check("gap_state", {62'd0, bit_valid, busy}, 64'b01);
        start = 1'b1;
        do_reset("rst_gap");
        cycle("post_rst_accept");
        check("post_rst_busy", 64'(busy), 64'd1);
        start = 1'b0;
        clear_obs();
        drain("post_rst_drain", 1'b0);
        cycle("post_rst_idle");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            ena     = ($urandom_range(0, 3) != 0);
            start   = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            pattern = 8'($urandom);
            len     = 3'($urandom);
            reps    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
